// File: rtl/inst_loader.sv
// ============================================================================
// Module   : inst_loader
// Brief    : Boot loader; packs a little-endian byte stream into 32-bit
//            instruction-memory writes after a 4-byte word-count header.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_loader #(
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              bad_inst
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [32:0]       c_CAPACITY = 33'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_BASE     = ADDR_W'(BASE_ADDR);

    state_t      r_state;
    logic [1:0]  r_bcnt;
    logic [31:0] r_idx;
    logic [31:0] r_n;
    logic [23:0] r_shift;

    logic [31:0]       w_word;
    logic              w_last_byte;
    logic              w_final;
    logic              w_too_big;
    logic [ADDR_W-1:0] w_addr;

    // Earlier bytes sit in the low positions, so the current byte is the MSB.
    assign w_word      = {rx_data, r_shift};
    assign w_last_byte = rx_valid && (r_bcnt == 2'd3);
    assign w_final     = (r_idx == (r_n - 32'd1));
    assign w_too_big   = ({1'b0, w_word} > c_CAPACITY);
    assign w_addr      = c_BASE + r_idx[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_bcnt     <= 2'd0;
            r_idx      <= 32'd0;
            r_n        <= 32'd0;
            r_shift    <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            bad_inst   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    // A byte arriving with start is intentionally dropped.
                    if (start) begin
                        r_state  <= S_HDR;
                        r_bcnt   <= 2'd0;
                        r_idx    <= 32'd0;
                        bad_inst <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (rx_valid) begin
                        r_bcnt  <= r_bcnt + 2'd1;
                        r_shift <= {rx_data, r_shift[23:8]};
                    end
                    if (w_last_byte) begin
                        r_n <= w_word;
                        if (w_word == 32'd0) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (w_too_big) begin
                            r_state <= S_ERR;
                            busy    <= 1'b0;
                            err     <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_bcnt  <= r_bcnt + 2'd1;
                        r_shift <= {rx_data, r_shift[23:8]};
                    end
                    if (w_last_byte) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= w_addr;
                        imem_wdata <= w_word;
                        r_idx      <= r_idx + 32'd1;
                        if (w_word[1:0] != 2'b11) begin
                            bad_inst <= 1'b1;
                        end
                        if (w_final) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// ============================================================================
// Module   : tb_inst_loader
// Brief    : Scoreboard bench for inst_loader (ADDR_W=4, BASE_ADDR=5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_loader;

    localparam int c_AW   = 4;
    localparam int c_BASE = 5;

    logic            clk;
    logic            rstn;
    logic            start;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            imem_we;
    logic [c_AW-1:0] imem_addr;
    logic [31:0]     imem_wdata;
    logic            busy;
    logic            done;
    logic            err;
    logic            bad_inst;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
        logic        bad;
    } exp_t;

    exp_t q_exp[$];
    int   n_vec;
    int   n_err;

    inst_loader #(
        .ADDR_W    (c_AW),
        .BASE_ADDR (c_BASE)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bad_inst   (bad_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the next queued expectation.
    always @(negedge clk) begin
        if (imem_we !== 1'b0) begin
            if (q_exp.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                check("wr_addr", 32'(imem_addr), e.addr);
                check("wr_data", imem_wdata, e.data);
                check("wr_done", {31'd0, done}, {31'd0, e.last});
                check("wr_bad",  {31'd0, bad_inst}, {31'd0, e.bad});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [31:0] data, input logic last, input logic bad);
        exp_t e;
        e.addr = 32'((c_BASE + idx) % (1 << c_AW));
        e.data = data;
        e.last = last;
        e.bad  = bad;
        q_exp.push_back(e);
    endtask

    // gap idle cycles precede the byte; inj allows stray start pulses during the gap.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit inj);
        for (int i = 0; i < gap; i++) begin
            start = inj ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        start    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gapped);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gapped ? int'($urandom_range(0, 3)) : 0, gapped);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 16 && q_exp.size() != 0; i++) tick();
        check(name, q_exp.size(), 0);
    endtask

    task automatic two_word_stream(input bit gapped);
        pulse_start();
        send_word(32'd2, gapped);
        push(0, 32'h00A0_0513, 1'b0, 1'b0);
        send_word(32'h00A0_0513, gapped);
        push(1, 32'h0000_006F, 1'b1, 1'b0);
        send_word(32'h0000_006F, gapped);
        drain("two_word_drain");
        check("two_word_done", {31'd0, done}, 32'd1);
        check("two_word_busy", {31'd0, busy}, 32'd0);
        check("two_word_bad",  {31'd0, bad_inst}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rstn     = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick();
        check("rst_we",    {31'd0, imem_we}, 32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_bad",   {31'd0, bad_inst}, 32'd0);
        rstn = 1'b1;
        tick();

        // Bytes before any start are ignored.
        send_word(32'h0000_0001, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        two_word_stream(1'b0);

        // Zero-length program.
        pulse_start();
        check("n0_busy_after_start", {31'd0, busy}, 32'd1);
        check("n0_done_cleared", {31'd0, done}, 32'd0);
        send_word(32'd0, 1'b0);
        check("n0_done", {31'd0, done}, 32'd1);
        check("n0_busy", {31'd0, busy}, 32'd0);

        // N = 17 exceeds 16-word capacity.
        pulse_start();
        send_word(32'd17, 1'b0);
        check("n17_err",  {31'd0, err}, 32'd1);
        check("n17_busy", {31'd0, busy}, 32'd0);
        send_word(32'h0000_0013, 1'b0);
        check("n17_err_hold", {31'd0, err}, 32'd1);

        // N = 16 fills the memory exactly; addresses wrap from BASE.
        pulse_start();
        check("n16_err_cleared", {31'd0, err}, 32'd0);
        send_word(32'd16, 1'b0);
        check("n16_in_data", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            push(i, 32'h1000_0003 | (32'(i) << 8), i == 15, 1'b0);
            send_word(32'h1000_0003 | (32'(i) << 8), 1'b0);
        end
        drain("n16_drain");
        check("n16_done", {31'd0, done}, 32'd1);

        // Non-32-bit encoding flags bad_inst.
        pulse_start();
        send_word(32'd1, 1'b0);
        push(0, 32'h0000_0000, 1'b1, 1'b1);
        send_word(32'h0000_0000, 1'b0);
        drain("bad_drain");
        tick();
        check("bad_held", {31'd0, bad_inst}, 32'd1);
        check("bad_done", {31'd0, done}, 32'd1);
        pulse_start();
        check("bad_cleared", {31'd0, bad_inst}, 32'd0);

        // Abort mid-word with reset.
        send_word(32'd2, 1'b0);
        send_byte(8'h13, 0, 1'b0);
        send_byte(8'h05, 0, 1'b0);
        rstn = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_we",   {31'd0, imem_we}, 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        two_word_stream(1'b0);

        // Gapped stream with stray start pulses mid-session.
        two_word_stream(1'b1);

        // start and a byte together: the byte must be dropped.
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h01;
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
        send_word(32'd0, 1'b0);
        check("drop_byte_done", {31'd0, done}, 32'd1);

        repeat (4) tick();
        check("final_queue_empty", q_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
